// File: rtl/flag_unit_pkg.sv
// Shared opcode, flag-index and update-mask definitions for the flag unit.
package flag_unit_pkg;

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned FLAG_W = 3;

    // Opcodes that write flags
    localparam logic [OPC_W-1:0] OP_ADD = 4'h0;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h1;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h2;
    localparam logic [OPC_W-1:0] OP_SLL = 4'h4;
    localparam logic [OPC_W-1:0] OP_SRA = 4'h5;
    localparam logic [OPC_W-1:0] OP_ROR = 4'h6;

    // Bit positions inside the {N,Z,V} flag vector
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    // Which flag bits an opcode is allowed to overwrite
    function automatic logic [FLAG_W-1:0] flag_mask(input logic [OPC_W-1:0] opcode);
        logic [FLAG_W-1:0] mask;
        mask = '0;
        case (opcode)
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b010;
            default:                        mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/flag_unit_pending_ctr.sv
// Saturating count of issued flag writers that have not reached EX yet.
module flag_pending_ctr #(
    parameter int unsigned MAX_PENDING = 3,
    parameter int unsigned CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;

    // Next count: flush discards every younger writer, including one issuing now
    always_comb begin
        cnt_nxt = cnt;
        err_nxt = err;
        if (flush) begin
            cnt_nxt = '0;
        end else if (inc && !dec) begin
            if (cnt == CNT_W'(MAX_PENDING)) begin
                err_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt == '0) begin
                err_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    // Counter and sticky error register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            err <= err_nxt;
        end
    end

endmodule

// File: rtl/flag_unit.sv
// Architectural {N,Z,V} flag register with EX forwarding and branch stall.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter  int unsigned MAX_PENDING = 3,
    parameter  int unsigned DATA_W      = 16,
    localparam int unsigned CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_issue,
    input  logic              id_sets_flags,
    input  logic              id_is_branch,
    input  logic              ex_valid,
    input  logic [OPC_W-1:0]  ex_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    input  logic              flush,
    output logic [FLAG_W-1:0] F,
    output logic              branch_stall,
    output logic [CNT_W-1:0]  pending_cnt,
    output logic              err
);

    logic [FLAG_W-1:0] flag_reg;
    logic [FLAG_W-1:0] mask;
    logic [FLAG_W-1:0] raw_flags;
    logic [FLAG_W-1:0] new_flags;
    logic              ex_write;

    // Merge fresh ALU flags into the held ones under the opcode mask
    always_comb begin
        raw_flags         = '0;
        raw_flags[FLAG_N] = alu_result[DATA_W-1];
        raw_flags[FLAG_Z] = (alu_result == '0);
        raw_flags[FLAG_V] = alu_ovf;
        mask              = flag_mask(ex_opcode);
        ex_write          = ex_valid && (mask != '0);
        new_flags         = (flag_reg & ~mask) | (raw_flags & mask);
    end

    // Architectural flag register, written one edge after EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_reg <= '0;
        end else if (ex_write) begin
            flag_reg <= new_flags;
        end
    end

    // Forward the EX write; stall a branch while an unforwarded writer is in flight
    always_comb begin
        F            = ex_write ? new_flags : flag_reg;
        branch_stall = id_is_branch &&
                       (CNT_W'(pending_cnt - CNT_W'(ex_write)) != '0);
    end

    flag_pending_ctr #(
        .MAX_PENDING (MAX_PENDING),
        .CNT_W       (CNT_W)
    ) u_pending_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (id_issue && id_sets_flags),
        .dec   (ex_write),
        .flush (flush),
        .cnt   (pending_cnt),
        .err   (err)
    );

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: vector table, hand sequences, random vs model.
module tb_flag_unit;

    logic        clk;
    logic        rst_n;
    logic        id_issue;
    logic        id_sets_flags;
    logic        id_is_branch;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] alu_result;
    logic        alu_ovf;
    logic        flush;
    logic [2:0]  F;
    logic        branch_stall;
    logic [1:0]  pending_cnt;
    logic        err;

    int checks   = 0;
    int failures = 0;

    // Reference state: flags as {N,Z,V}, in-flight writer count, sticky error
    logic [2:0] m_flags;
    int         m_pend;
    bit         m_err;

    logic [2:0] last_f;
    logic       last_stall;

    typedef struct {
        logic        ev;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovf;
        logic [2:0]  exp_f;
    } vec_t;

    vec_t tbl[15];

    flag_unit #(.MAX_PENDING(3), .DATA_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_issue      (id_issue),
        .id_sets_flags (id_sets_flags),
        .id_is_branch  (id_is_branch),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .alu_result    (alu_result),
        .alu_ovf       (alu_ovf),
        .flush         (flush),
        .F             (F),
        .branch_stall  (branch_stall),
        .pending_cnt   (pending_cnt),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_issue = 0; id_sets_flags = 0; id_is_branch = 0; ex_valid = 0;
        ex_opcode = 4'h0; alu_result = 16'h0; alu_ovf = 0; flush = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        m_flags = 3'b000; m_pend = 0; m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One cycle: check all outputs against the model mid-cycle, then advance the model
    task automatic step();
        bit         upd_nzv, upd_z, wr, inc, exp_stall;
        logic [2:0] nf;
        upd_nzv = (ex_opcode == 4'd0) || (ex_opcode == 4'd1);
        upd_z   = upd_nzv || (ex_opcode inside {4'd2, 4'd4, 4'd5, 4'd6});
        wr      = ex_valid && upd_z;
        inc     = id_issue && id_sets_flags;
        nf      = m_flags;
        if (wr) begin
            if (upd_nzv) begin
                nf[2] = alu_result[15];
                nf[0] = alu_ovf;
            end
            nf[1] = (alu_result == 16'd0);
        end
        exp_stall = id_is_branch && ((m_pend - int'(wr)) != 0);
        @(negedge clk);
        chk("F", int'(F), int'(nf));
        chk("branch_stall", int'(branch_stall), int'(exp_stall));
        chk("pending_cnt", int'(pending_cnt), m_pend);
        chk("err", int'(err), int'(m_err));
        last_f     = F;
        last_stall = branch_stall;
        m_flags = nf;
        if (flush) begin
            m_pend = 0;
        end else if (inc && !wr) begin
            if (m_pend == 3) m_err = 1; else m_pend++;
        end else if (wr && !inc) begin
            if (m_pend == 0) m_err = 1; else m_pend--;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'h0, 16'h0000, 1'b0, 3'b010}; // ADD zero
        tbl[1]  = '{1'b0, 4'h0, 16'h1234, 1'b1, 3'b010}; // idle: register holds 010
        tbl[2]  = '{1'b1, 4'h1, 16'h8000, 1'b1, 3'b101}; // SUB negative, ovf
        tbl[3]  = '{1'b0, 4'h1, 16'h0000, 1'b0, 3'b101};
        tbl[4]  = '{1'b1, 4'h2, 16'h0000, 1'b0, 3'b111}; // XOR: Z only
        tbl[5]  = '{1'b1, 4'h8, 16'h5555, 1'b0, 3'b111}; // LW: no update
        tbl[6]  = '{1'b1, 4'h0, 16'h1234, 1'b0, 3'b000};
        tbl[7]  = '{1'b1, 4'h4, 16'h8000, 1'b1, 3'b000}; // SLL: N/V held
        tbl[8]  = '{1'b1, 4'h5, 16'h0000, 1'b1, 3'b010}; // SRA
        tbl[9]  = '{1'b1, 4'h6, 16'h0001, 1'b0, 3'b000}; // ROR
        tbl[10] = '{1'b0, 4'h0, 16'h0000, 1'b0, 3'b000}; // not valid
        tbl[11] = '{1'b1, 4'h3, 16'h0000, 1'b1, 3'b000}; // non-updating opcode
        tbl[12] = '{1'b1, 4'h1, 16'hFFFF, 1'b0, 3'b100};
        tbl[13] = '{1'b1, 4'hF, 16'h0000, 1'b1, 3'b100};
        tbl[14] = '{1'b0, 4'h0, 16'h0000, 1'b0, 3'b100};

        rst_n = 1'b0;
        idle_inputs();
        #3;
        chk("reset_F", int'(F), 0);
        chk("reset_pending", int'(pending_cnt), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_stall", int'(branch_stall), 0);
        apply_reset();

        // Flag update rules and forwarding
        for (int i = 0; i < 15; i++) begin
            ex_valid = tbl[i].ev; ex_opcode = tbl[i].op;
            alu_result = tbl[i].res; alu_ovf = tbl[i].ovf;
            step();
            chk($sformatf("tbl_F[%0d]", i), int'(last_f), int'(tbl[i].exp_f));
        end

        // Branch waits on an in-flight ADD, then sees its flags forwarded
        apply_reset();
        idle_inputs(); id_issue = 1; id_sets_flags = 1; step();
        idle_inputs(); id_is_branch = 1; step();
        chk("seq_stall_inflight", int'(last_stall), 1);
        idle_inputs(); id_is_branch = 1; ex_valid = 1; ex_opcode = 4'h0; alu_result = 16'h0; step();
        chk("seq_stall_fwd", int'(last_stall), 0);
        chk("seq_F_fwd", int'(last_f), 3'b010);

        // Simultaneous issue and write, then flush with a writer issuing
        idle_inputs(); id_issue = 1; id_sets_flags = 1; step();
        idle_inputs(); id_issue = 1; id_sets_flags = 1; ex_valid = 1; ex_opcode = 4'h1;
        alu_result = 16'h0001; step();
        chk("seq_pend_both", int'(pending_cnt), 1);
        idle_inputs(); id_issue = 1; id_sets_flags = 1; flush = 1; step();
        chk("seq_pend_flush", int'(pending_cnt), 0);

        // Underflow and saturation set the sticky error
        apply_reset();
        idle_inputs(); ex_valid = 1; ex_opcode = 4'h0; alu_result = 16'h7; step();
        chk("seq_underflow_err", int'(err), 1);
        chk("seq_underflow_pend", int'(pending_cnt), 0);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            idle_inputs(); id_issue = 1; id_sets_flags = 1; step();
        end
        chk("seq_sat_pend", int'(pending_cnt), 3);
        chk("seq_sat_err", int'(err), 1);

        // Randomized traffic against the model
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            id_issue      = 1'($urandom_range(0, 1));
            id_sets_flags = 1'($urandom_range(0, 1));
            id_is_branch  = 1'($urandom_range(0, 1));
            ex_valid      = 1'($urandom_range(0, 1));
            ex_opcode     = 4'($urandom_range(0, 15));
            alu_result    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            alu_ovf       = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 15) == 0);
            step();
        end

        // Asynchronous reset mid-run with flags 111 and two writers pending
        apply_reset();
        idle_inputs(); ex_valid = 1; ex_opcode = 4'h1; alu_result = 16'h8000; alu_ovf = 1; step();
        idle_inputs(); ex_valid = 1; ex_opcode = 4'h2; alu_result = 16'h0000; step();
        idle_inputs(); id_issue = 1; id_sets_flags = 1; step();
        idle_inputs(); id_issue = 1; id_sets_flags = 1; step();
        idle_inputs(); id_is_branch = 1;
        chk("pre_rst_F", int'(F), 3'b111);
        chk("pre_rst_pend", int'(pending_cnt), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_F", int'(F), 0);
        chk("async_rst_pend", int'(pending_cnt), 0);
        chk("async_rst_err", int'(err), 0);
        chk("async_rst_stall", int'(branch_stall), 0);
        m_flags = 3'b000; m_pend = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer end of the {N,Z,V} flag interface consumed by the branch PC control block.
- Holds the architectural flag register and updates it from EX-stage ALU results, using per-opcode update rules.
- Drives F to the decode-stage branch logic, with same-cycle forwarding of the EX-stage write.
- Tracks issued flag-setting instructions that have not yet written their flags, and stalls a decode-stage branch that would otherwise read stale flags.

Parameters:
- MAX_PENDING, 3, saturation limit of the pending flag-writer counter; counter width is clog2(MAX_PENDING+1).
- DATA_W, 16, ALU result width.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- id_issue, input, 1, the decode-stage instruction advances to EX this cycle.
- id_sets_flags, input, 1, the issuing instruction is a flag writer; qualified by id_issue.
- id_is_branch, input, 1, the decode-stage instruction is a conditional branch (B/BR).
- ex_valid, input, 1, the EX stage holds a live instruction this cycle.
- ex_opcode, input, 4, EX-stage opcode.
- alu_result, input, DATA_W, EX-stage ALU result.
- alu_ovf, input, 1, signed overflow from the EX-stage ALU.
- flush, input, 1, squash all instructions younger than EX; asserted on a taken branch.
- F, output, 3, flags to branch control: F[2]=N, F[1]=Z, F[0]=V.
- branch_stall, output, 1, hold the decode-stage branch this cycle.
- pending_cnt, output, clog2(MAX_PENDING+1), debug view of the pending counter.
- err, output, 1, sticky protocol error flag.

Behaviour:
- Reset (asynchronous, rst_n=0): flag_reg=3'b000, pending=0, err=0. As a result, F=000, branch_stall=0 and pending_cnt=0 while reset is held.
- Update rules, evaluated when ex_valid=1:
  - ADD 0000 and SUB 0001 update N, Z and V.
  - XOR 0010, SLL 0100, SRA 0101 and ROR 0110 update Z only.
  - All other opcodes update nothing.
  - ex_write = ex_valid AND (opcode in either updating set).
- Flag values:
  - Z = (alu_result == 0).
  - N = alu_result[DATA_W-1].
  - V = alu_ovf.
  - Bits that the opcode does not update keep their flag_reg value.
- Write timing: the merged value (new_flags) is registered into flag_reg on the clock edge after the EX cycle. Write latency is 1 cycle.
- Forwarding: F = ex_write ? new_flags : flag_reg. This is combinational, so there are zero cycles between EX and branch visibility.
- Pending counter update per edge:
  - +1 when id_issue AND id_sets_flags.
  - -1 when ex_write.
  - Unchanged when both occur in the same cycle.
- Stall: branch_stall = id_is_branch AND ((pending - ex_write) != 0). Result: stall when a writer is still in flight and is not being forwarded this cycle.
- Flush:
  - Next pending = (id_issue AND id_sets_flags AND NOT flush) ? 1 : 0.
  - Younger writers are discarded.
  - An ex_write in the flush cycle still commits, because EX is older than the branch.
- Boundary conditions:
  - Decrement requested at pending=0: counter stays 0 and err is set.
  - Increment requested at MAX_PENDING: counter saturates and err is set.
  - err clears only on reset.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values. In-flight writers are forgotten.

Decomposition:
- Shared package holds:
  - opcode localparams (ADD..ROR);
  - flag bit index constants FLAG_N=2, FLAG_Z=1, FLAG_V=0;
  - a flag-update-mask function mapping opcode to a 3-bit mask.
- Sub-module flag_pending_ctr contains the saturating up/down counter with flush and err. The top level keeps the flag register, the merge logic and the stall logic.

Test Plan:
- Reset: rst_n=0 mid-run with flag_reg=111 and pending=2 -> F=000, pending_cnt=0, err=0 asynchronously, before the next edge.
- ADD result 0x0000 with ovf=0 -> F=010 in the same cycle, flag_reg=010 after the edge. Then SUB result 0x8000 with ovf=1 -> F=101.
- With flag_reg=101: XOR result 0x0000 -> F=111 (N and V held, Z set). Then LW (opcode 1000) with any result -> F unchanged at 111.
- Issue ADD (pending=1) and present a branch in ID the next cycle with the ADD still not in EX -> branch_stall=1. In the cycle the ADD is ex_write with result 0x0000 -> branch_stall=0 and F=010.
- Same cycle: id_issue+id_sets_flags and ex_write -> pending unchanged at 1. Then flush with a writer issuing -> pending=0.
- ex_write with pending=0 -> err=1 and pending stays 0. Four consecutive writer issues with no EX writes -> pending saturates at 3 and err=1.
